// File: rtl/fft_frame_ctrl.sv
// Purpose : frames 2^M unsigned 8-bit samples into an FFT core, kicks it, and
//           streams its result bins back out with a running index.
// Latency : one cycle from sample accept to fft_load, and from fft_done to bin_valid.
// Backpressure: smp_ready is high only while loading; fft_done gaps stall the bin stream.
//
// Optional build macro FFT_FRAME_TIMEOUT_EN: adds a watchdog on the wait for
// fft_done. The default build waits indefinitely and ties timeout_err to 0.
//
// Ports
//   clk, reset_n      : clock (rising edge), asynchronous active-low reset
//   enable            : keep running frames back to back while high
//   smp_valid/ready   : sample handshake, smp_data is the 8-bit sample
//   fft_load/rd_adr/rd: FFT input-write strobe, address and {re, im} word
//   fft_start         : single-cycle start pulse after the last input write
//   fft_done/fft_wd   : FFT result streaming qualifier and {re, im} word
//   bin_valid/idx/re/im: registered result bin with running index
//   frame_done        : pulses with the last bin of a frame
//   busy, frame_cnt   : not-idle status, completed-frame counter (wraps)
//   timeout_err       : sticky watchdog flag, cleared when the next frame starts loading
module fft_frame_ctrl #(
    parameter int M           = 9,
    parameter int WIDTH       = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    smp_valid,
    input  logic [7:0]              smp_data,
    output logic                    smp_ready,
    output logic                    fft_load,
    output logic [M-1:0]            fft_rd_adr,
    output logic [2*WIDTH-1:0]      fft_rd,
    output logic                    fft_start,
    input  logic                    fft_done,
    input  logic [2*WIDTH-1:0]      fft_wd,
    output logic                    bin_valid,
    output logic [M-1:0]            bin_idx,
    output logic signed [WIDTH-1:0] bin_re,
    output logic signed [WIDTH-1:0] bin_im,
    output logic                    frame_done,
    output logic                    busy,
    output logic [7:0]              frame_cnt,
    output logic                    timeout_err
);

    localparam int         POINTS   = 1 << M;
    localparam logic [M:0] LAST_BIN = (M+1)'(POINTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KICK,
        S_WAIT,
        S_UNLOAD
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [M-1:0]         r_load_cnt;
    // One bit wider than an index: the top bit marks "all bins seen" so a
    // stray fft_done in the frame_done cycle cannot start a second pass.
    logic [M:0]           r_bin_cnt;
    logic                 r_fft_load;
    logic [M-1:0]         r_fft_rd_adr;
    logic [2*WIDTH-1:0]   r_fft_rd;
    logic                 r_fft_start;
    logic                 r_bin_valid;
    logic [M-1:0]         r_bin_idx;
    logic [WIDTH-1:0]     r_bin_re;
    logic [WIDTH-1:0]     r_bin_im;
    logic                 r_frame_done;
    logic [7:0]           r_frame_cnt;
    logic                 r_timeout_err;

    logic                 w_accept;
    logic                 w_load_last;
    logic                 w_capture;
    logic                 w_bin_last;
    logic                 w_timeout;
    logic                 w_enter_load;
    logic [2*WIDTH-1:0]   w_smp_word;

    // Sample lands zero-extended in the real half, imaginary half is zero.
    assign w_smp_word  = {{(WIDTH-8){1'b0}}, smp_data, {WIDTH{1'b0}}};
    assign w_accept    = (r_state == S_LOAD) && smp_valid;
    assign w_load_last = w_accept && (&r_load_cnt);
    // The fft_done cycle that moves WAIT to UNLOAD already carries bin 0.
    assign w_capture   = fft_done && ((r_state == S_WAIT) ||
                                      ((r_state == S_UNLOAD) && !r_bin_cnt[M]));
    assign w_bin_last  = w_capture && (r_bin_cnt == LAST_BIN);

`ifdef FFT_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_wait_cnt;

    assign w_timeout = (r_state == S_WAIT) && !fft_done &&
                       (r_wait_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != S_WAIT) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_enter_load) begin
                r_timeout_err <= 1'b0;
            end else if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end
`else
    // The watchdog depth has no effect when the watchdog is not built.
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign w_timeout     = 1'b0;
    assign r_timeout_err = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_next = S_LOAD;
            S_LOAD:   if (w_load_last) w_next = S_KICK;
            S_KICK:   w_next = S_WAIT;
            S_WAIT: begin
                if (fft_done) begin
                    w_next = S_UNLOAD;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            // Leave once the last bin is on the outputs; enable is sampled here
            // so a mid-frame drop only takes effect at the frame boundary.
            S_UNLOAD: if (r_frame_done) w_next = enable ? S_LOAD : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    assign w_enter_load = (w_next == S_LOAD) && (r_state != S_LOAD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_load_cnt   <= '0;
            r_bin_cnt    <= '0;
            r_fft_load   <= 1'b0;
            r_fft_rd_adr <= '0;
            r_fft_rd     <= '0;
            r_fft_start  <= 1'b0;
            r_bin_valid  <= 1'b0;
            r_bin_idx    <= '0;
            r_bin_re     <= '0;
            r_bin_im     <= '0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state <= w_next;

            // Held at zero outside LOAD, so every frame starts at address 0.
            if (r_state != S_LOAD) begin
                r_load_cnt <= '0;
            end else if (w_accept) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end

            r_fft_load   <= w_accept;
            r_fft_rd_adr <= w_accept ? r_load_cnt : '0;
            r_fft_rd     <= w_accept ? w_smp_word : '0;

            // KICK follows the last accept, so this pulse trails the last fft_load.
            r_fft_start <= (r_state == S_KICK);

            // Zero on the way into WAIT/UNLOAD; the bin stream indexes from it.
            if ((r_state != S_WAIT) && (r_state != S_UNLOAD)) begin
                r_bin_cnt <= '0;
            end else if (w_capture) begin
                r_bin_cnt <= r_bin_cnt + 1'b1;
            end

            r_bin_valid <= w_capture;
            if (w_capture) begin
                r_bin_idx <= r_bin_cnt[M-1:0];
                r_bin_re  <= fft_wd[2*WIDTH-1:WIDTH];
                r_bin_im  <= fft_wd[WIDTH-1:0];
            end

            r_frame_done <= w_bin_last;
            if (w_bin_last) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

    assign smp_ready   = (r_state == S_LOAD);
    assign busy        = (r_state != S_IDLE);
    assign fft_load    = r_fft_load;
    assign fft_rd_adr  = r_fft_rd_adr;
    assign fft_rd      = r_fft_rd;
    assign fft_start   = r_fft_start;
    assign bin_valid   = r_bin_valid;
    assign bin_idx     = r_bin_idx;
    assign bin_re      = r_bin_re;
    assign bin_im      = r_bin_im;
    assign frame_done  = r_frame_done;
    assign frame_cnt   = r_frame_cnt;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Purpose : self-checking bench for fft_frame_ctrl (M=9, WIDTH=16).
// Latency : inputs change on the falling edge, outputs are sampled on the falling edge.
// Backpressure: sample offers follow a frame-level reference model of the loader.
module tb_fft_frame_ctrl;

    localparam int M       = 9;
    localparam int WIDTH   = 16;
    localparam int TMO     = 4096;
    localparam int POINTS  = 512;

    localparam int PH_IDLE   = 0;
    localparam int PH_LOAD   = 1;
    localparam int PH_KICK   = 2;
    localparam int PH_WAIT   = 3;
    localparam int PH_UNLOAD = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        smp_valid;
    logic [7:0]  smp_data;
    logic        smp_ready;
    logic        fft_load;
    logic [8:0]  fft_rd_adr;
    logic [31:0] fft_rd;
    logic        fft_start;
    logic        fft_done;
    logic [31:0] fft_wd;
    logic        bin_valid;
    logic [8:0]  bin_idx;
    logic [15:0] bin_re;
    logic [15:0] bin_im;
    logic        frame_done;
    logic        busy;
    logic [7:0]  frame_cnt;
    logic        timeout_err;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.M(M), .WIDTH(WIDTH), .TIMEOUT_CYC(TMO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .smp_valid  (smp_valid),
        .smp_data   (smp_data),
        .smp_ready  (smp_ready),
        .fft_load   (fft_load),
        .fft_rd_adr (fft_rd_adr),
        .fft_rd     (fft_rd),
        .fft_start  (fft_start),
        .fft_done   (fft_done),
        .fft_wd     (fft_wd),
        .bin_valid  (bin_valid),
        .bin_idx    (bin_idx),
        .bin_re     (bin_re),
        .bin_im     (bin_im),
        .frame_done (frame_done),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic        rdy;
        logic        bsy;
        logic        ld;
        logic [8:0]  adr;
        logic [31:0] rd;
        logic        st;
        logic        bv;
        logic [8:0]  idx;
        logic [15:0] re;
        logic [15:0] im;
        logic        fd;
        logic [7:0]  fcnt;
        logic        terr;
    } obs_t;

    typedef struct {
        logic        en;
        logic        val;
        logic [7:0]  dat;
        logic        rdy;
        logic        bsy;
        logic        ld;
        logic [8:0]  adr;
        logic [31:0] rd;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Reference model: frame phase, samples taken, bins delivered, wait cycles.
    int   m_ph, m_nl, m_nb, m_wc;
    obs_t e;

    // Monitors.
    int n_load, n_start, n_bins, n_good, n_fd;
    int first_adr, last_adr, first_load_cyc, last_load_cyc, start_cyc;
    int fd_idx, resume_idx, terr_cyc;
    int bin_cyc [POINTS];
    bit prev_bv, prev_terr;

    function automatic obs_t get_obs();
        obs_t o;
        o.rdy  = smp_ready;  o.bsy = busy;       o.ld  = fft_load;
        o.adr  = fft_rd_adr; o.rd  = fft_rd;     o.st  = fft_start;
        o.bv   = bin_valid;  o.idx = bin_idx;    o.re  = bin_re;
        o.im   = bin_im;     o.fd  = frame_done; o.fcnt = frame_cnt;
        o.terr = timeout_err;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_ph = PH_IDLE; m_nl = 0; m_nb = 0; m_wc = 0;
        e = '0;
    endtask

    task automatic go_load();
        m_ph   = PH_LOAD;
        m_nl   = 0;
        e.terr = 1'b0;
    endtask

    // One clock of the frame rules, using the inputs present at the edge.
    task automatic model_step();
        bit acc, cap, prev_fd;
        prev_fd = e.fd;
        acc = (m_ph == PH_LOAD) && smp_valid;
        cap = fft_done && (m_ph == PH_WAIT || (m_ph == PH_UNLOAD && m_nb < POINTS));
        e.ld  = acc;
        e.adr = acc ? m_nl[8:0] : 9'd0;
        e.rd  = acc ? {8'h00, smp_data, 16'h0000} : 32'd0;
        e.st  = (m_ph == PH_KICK);
        e.bv  = cap;
        if (cap) begin
            e.idx = m_nb[8:0];
            e.re  = fft_wd[31:16];
            e.im  = fft_wd[15:0];
        end
        e.fd = cap && (m_nb == POINTS - 1);
        if (e.fd) e.fcnt = e.fcnt + 8'd1;
        case (m_ph)
            PH_IDLE: if (enable) go_load();
            PH_LOAD: if (acc) begin
                m_nl++;
                if (m_nl == POINTS) m_ph = PH_KICK;
            end
            PH_KICK: begin m_ph = PH_WAIT; m_nb = 0; m_wc = 0; end
            PH_WAIT: begin
                if (fft_done) begin
                    m_nb = 1;
                    m_ph = PH_UNLOAD;
                end else begin
                    m_wc++;
`ifdef FFT_FRAME_TIMEOUT_EN
                    if (m_wc == TMO) begin m_ph = PH_IDLE; e.terr = 1'b1; end
`endif
                end
            end
            default: begin
                if (cap) m_nb++;
                if (prev_fd) begin
                    if (enable) go_load();
                    else m_ph = PH_IDLE;
                end
            end
        endcase
        e.rdy = (m_ph == PH_LOAD);
        e.bsy = (m_ph != PH_IDLE);
    endtask

    task automatic clr_mon();
        n_load = 0; n_start = 0; n_bins = 0; n_good = 0; n_fd = 0;
        first_adr = -1; last_adr = -1; first_load_cyc = 0; last_load_cyc = 0;
        start_cyc = 0; fd_idx = -1; resume_idx = -1; terr_cyc = -1;
        prev_bv = 0; prev_terr = 0;
        for (int i = 0; i < POINTS; i++) bin_cyc[i] = -1;
    endtask

    task automatic cycle();
        obs_t o;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        o = get_obs();
        n_total++;
        if (o === e) n_pass++;
        else $display("FAIL cycle_model cycle %0d: got %h, expected %h", cyc, o, e);
        if (o.ld) begin
            if (n_load == 0) begin first_adr = int'(o.adr); first_load_cyc = cyc; end
            last_adr = int'(o.adr); last_load_cyc = cyc; n_load++;
        end
        if (o.st) begin n_start++; start_cyc = cyc; end
        if (o.bv) begin
            n_bins++;
            if (o.re == 16'h0001 && o.im == 16'hFFFF) n_good++;
            bin_cyc[o.idx] = cyc;
            if (!prev_bv && n_bins > 1) resume_idx = int'(o.idx);
        end
        prev_bv = o.bv;
        if (o.fd) begin n_fd++; fd_idx = int'(o.idx); end
        if (o.terr && !prev_terr) terr_cyc = cyc;
        prev_terr = o.terr;
    endtask

    // Called on a falling edge; the reset must clear the outputs without a clock.
    task automatic do_reset();
        obs_t o;
        reset_n = 1'b0; enable = 1'b0; smp_valid = 1'b0; smp_data = 8'h00;
        fft_done = 1'b0; fft_wd = 32'h0;
        #1;
        o = get_obs();
        check("reset_outputs_zero", 64'(o), 64'd0);
        check("reset_outputs_zero_hi", 64'(o >> 64), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_frame(input int drop_at, input bit rnd);
        int k = 0;
        int g = 0;
        enable = 1'b1;
        while (k < POINTS && g < 4000) begin
            if (k == drop_at) enable = 1'b0;
            smp_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            smp_data  = rnd ? 8'($urandom) : 8'(k);
            fft_done  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            fft_wd    = $urandom;
            if (m_ph == PH_LOAD && smp_valid) k++;
            cycle();
            g++;
        end
        smp_valid = 1'b0;
        fft_done  = 1'b0;
        check("load_bound", 64'(k), 64'(POINTS));
    endtask

    task automatic unload_frame(input int gap_at, input bit rnd, input logic [31:0] wd);
        int g = 0;
        int h = 0;
        int gl;
        bit got_fd = 0;
        gl = (gap_at >= 0) ? 3 : 0;
        fft_done = 1'b0;
        while (m_ph != PH_WAIT && g < 50) begin cycle(); g++; end
        repeat (3) cycle();
        g = 0;
        while (!got_fd && g < 4000) begin
            if (gap_at >= 0 && h == gap_at + 1 && gl > 0) begin
                fft_done = 1'b0; gl--;
            end else begin
                fft_done = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            fft_wd = rnd ? $urandom : wd;
            if (fft_done) h++;
            cycle();
            g++;
            if (e.fd) got_fd = 1;
        end
        fft_done = 1'b0;
        check("unload_bound", 64'(got_fd), 64'd1);
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{en:1'b0, val:1'b1, dat:8'h55, rdy:1'b0, bsy:1'b0, ld:1'b0, adr:9'd0, rd:32'h0};
        tbl[1] = '{en:1'b1, val:1'b1, dat:8'hAA, rdy:1'b1, bsy:1'b1, ld:1'b0, adr:9'd0, rd:32'h0};
        tbl[2] = '{en:1'b1, val:1'b1, dat:8'h11, rdy:1'b1, bsy:1'b1, ld:1'b1, adr:9'd0, rd:32'h0011_0000};
        tbl[3] = '{en:1'b1, val:1'b0, dat:8'h77, rdy:1'b1, bsy:1'b1, ld:1'b0, adr:9'd0, rd:32'h0};
        tbl[4] = '{en:1'b0, val:1'b1, dat:8'h22, rdy:1'b1, bsy:1'b1, ld:1'b1, adr:9'd1, rd:32'h0022_0000};
        tbl[5] = '{en:1'b0, val:1'b1, dat:8'hFF, rdy:1'b1, bsy:1'b1, ld:1'b1, adr:9'd2, rd:32'h00FF_0000};

        clr_mon();
        @(negedge clk);
        do_reset();

        // Table: idle hold, LOAD entry, accept/no-accept, enable drop mid-load.
        for (int i = 0; i < 6; i++) begin
            enable = tbl[i].en; smp_valid = tbl[i].val; smp_data = tbl[i].dat;
            cycle();
            check($sformatf("tbl_vec%0d", i),
                  64'({smp_ready, busy, fft_load, fft_rd_adr, fft_rd}),
                  64'({tbl[i].rdy, tbl[i].bsy, tbl[i].ld, tbl[i].adr, tbl[i].rd}));
        end

        // Reset from mid-LOAD, then the back-to-back ramp frame.
        do_reset();
        clr_mon();
        load_frame(-1, 1'b0);
        enable = 1'b0;
        unload_frame(-1, 1'b0, 32'h0001_FFFF);
        cycle();
        check("s1_load_count",     64'(n_load), 64'd512);
        check("s1_load_contig",    64'(last_load_cyc - first_load_cyc), 64'd511);
        check("s1_first_adr",      64'(first_adr), 64'd0);
        check("s1_last_adr",       64'(last_adr), 64'd511);
        check("s1_start_count",    64'(n_start), 64'd1);
        check("s1_start_after",    64'(start_cyc - last_load_cyc), 64'd1);
        check("s1_bin_count",      64'(n_bins), 64'd512);
        check("s1_bin_re1_imm1",   64'(n_good), 64'd512);
        check("s1_bin_contig",     64'(bin_cyc[511] - bin_cyc[0]), 64'd511);
        check("s1_fd_count",       64'(n_fd), 64'd1);
        check("s1_fd_idx",         64'(fd_idx), 64'd511);
        check("s1_frame_cnt",      64'(frame_cnt), 64'd1);
        check("s1_idle_busy",      64'(busy), 64'd0);

        // Enable dropped at sample 200, three-cycle fft_done gap after bin 100.
        clr_mon();
        load_frame(200, 1'b1);
        unload_frame(100, 1'b0, 32'h0001_FFFF);
        cycle();
        check("s2_gap_len",        64'(bin_cyc[101] - bin_cyc[100] - 1), 64'd3);
        check("s2_resume_idx",     64'(resume_idx), 64'd101);
        check("s2_bin_count",      64'(n_bins), 64'd512);
        check("s2_fd_idx",         64'(fd_idx), 64'd511);
        check("s2_frame_cnt",      64'(frame_cnt), 64'd2);
        check("s2_busy_after",     64'(busy), 64'd0);
        check("s2_ready_after",    64'(smp_ready), 64'd0);

        // Randomized back-to-back frames with enable held high.
        for (int f = 0; f < 2; f++) begin
            clr_mon();
            load_frame(-1, 1'b1);
            unload_frame(-1, 1'b1, 32'h0);
            check($sformatf("s3_fd_count%0d", f), 64'(n_fd), 64'd1);
        end
        cycle();
        check("s3_frame_cnt",      64'(frame_cnt), 64'd4);
        check("s3_reload_ready",   64'(smp_ready), 64'd1);

        // Reset in the middle of UNLOAD.
        load_frame(-1, 1'b1);
        fft_done = 1'b0;
        for (int g = 0; g < 50 && m_ph != PH_WAIT; g++) cycle();
        fft_done = 1'b1;
        repeat (50) begin fft_wd = $urandom; cycle(); end
        check("s4_mid_unload",     64'(bin_valid), 64'd1);
        do_reset();
        clr_mon();
        load_frame(-1, 1'b0);
        enable = 1'b0;
        check("s4_first_adr",      64'(first_adr), 64'd0);
        check("s4_frame_cnt_zero", 64'(frame_cnt), 64'd0);

`ifdef FFT_FRAME_TIMEOUT_EN
        begin
            int g = 0;
            fft_done = 1'b0;
            while (m_ph != PH_IDLE && g < 6000) begin cycle(); g++; end
            check("s5_timeout_err",  64'(timeout_err), 64'd1);
            check("s5_idle",         64'(busy), 64'd0);
            check("s5_frame_cnt",    64'(frame_cnt), 64'd0);
            check("s5_no_frame_done",64'(n_fd), 64'd0);
            check("s5_wait_cycles",  64'(terr_cyc - start_cyc), 64'(TMO));
            enable = 1'b1;
            cycle();
            check("s5_err_cleared",  64'(timeout_err), 64'd0);
            enable = 1'b0;
        end
`else
        fft_done = 1'b0;
        repeat (4200) cycle();
        check("s5_still_waiting",  64'(busy), 64'd1);
        check("s5_err_tied_low",   64'(timeout_err), 64'd0);
        unload_frame(-1, 1'b0, 32'h1234_5678);
        cycle();
        check("s5_frame_cnt",      64'(frame_cnt), 64'd1);
        check("s5_idle",           64'(busy), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
